regfile_2w2r_sb: RTL and testbench
==================================

Name: regfile_2w2r_sb

Overview:
- Parametrised multi-port register file for the pipelined datapath; successor to the fixed 32x64 single-write register file.
- Two write ports with fixed priority, two read ports, optional write-to-read bypass, and optional registered reads.
- Optional hardwired-zero register.
- Per-register busy scoreboard so issue logic can detect pending writes to a source register.

Parameters:
- N, 64, data width in bits.
- ADDR_W, 5, address width; depth is 2**ADDR_W.
- HAS_ZERO, 1, 1 = register ZERO_IDX reads 0 and ignores writes.
- ZERO_IDX, 31, index of the hardwired-zero register.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports.
- READ_REG, 0, 0 = combinational reads; 1 = reads registered with 1-cycle latency.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- D0  in  N  write data, port 0.
- DA0  in  ADDR_W  write address, port 0.
- W0  in  1  write enable, port 0.
- D1  in  N  write data, port 1.
- DA1  in  ADDR_W  write address, port 1.
- W1  in  1  write enable, port 1.
- SA  in  ADDR_W  read select A.
- SB  in  ADDR_W  read select B.
- SET  in  1  mark register SETA busy (producer issued).
- SETA  in  ADDR_W  register to mark busy.
- A  out  N  read data A.
- B  out  N  read data B.
- A_busy  out  1  register selected by SA has a pending write.
- B_busy  out  1  register selected by SB has a pending write.

Behaviour:
- Reset (async, active-high):
  - All storage registers cleared to 0.
  - All busy bits cleared.
  - Registered outputs A and B (READ_REG=1) cleared to 0.
  - Reset asserted mid-operation discards any write, SET or registered read in flight; no partial update.
- Writes, at the rising edge:
  - W0 updates reg[DA0] with D0; W1 updates reg[DA1] with D1.
  - W0 and W1 to the same address: port 1 wins.
  - Writes to ZERO_IDX when HAS_ZERO=1 are ignored.
- Read value V(S), where S is SA or SB:
  - HAS_ZERO=1 and S=ZERO_IDX: 0.
  - Else, BYPASS=1 and W1 with DA1=S: D1.
  - Else, BYPASS=1 and W0 with DA0=S: D0.
  - Else: reg[S].
- READ_REG=0: A=V(SA), B=V(SB), combinational; 0-cycle latency.
- READ_REG=1: at the edge, A<=V(SA) and B<=V(SB); 1-cycle latency. With BYPASS=0, a coincident write is not visible until the following read.
- Scoreboard, at the edge:
  - A write on either port to address X clears busy[X].
  - SET=1 sets busy[SETA].
  - SET and a clear to the same address in the same cycle: set wins, since a new producer supersedes the old one.
  - ZERO_IDX is never busy when HAS_ZERO=1.
- Busy outputs:
  - A_busy = busy[SA] & ~(BYPASS & pending write this cycle to SA); likewise B_busy for SB. Combinational in both READ_REG modes.
  - Zero register reports 0.
- Address wrap: addresses are full ADDR_W width, so every code is a valid register and no out-of-range case exists.

Decomposition:
- Shared package regfile_pkg: default N and ADDR_W, ZERO_IDX default, and a function computing the depth from ADDR_W.
- One natural sub-module, rf_read_port: zero/bypass/priority read-value selection for a single read port, instantiated twice (A and B).
- Storage, scoreboard and write logic stay in the top module.

Test Plan:
- Reset, then read all 32 addresses on A and B -> all read 0, A_busy=B_busy=0.
- W0=1, DA0=5, D0=64'h1234; next cycle SA=5 -> A=64'h1234. With BYPASS=1 and READ_REG=0, A=64'h1234 in the same cycle as the write.
- W0=1, DA0=7, D0=64'hAAAA and W1=1, DA1=7, D1=64'h5555 together; then read SA=7 -> A=64'h5555 (port 1 wins).
- W1=1, DA1=31, D1=64'hFFFF; then SA=31 -> A=0.
- SET=1, SETA=3 -> A_busy=1 with SA=3.
  - W0 to 3 -> A_busy=0 in that cycle (BYPASS=1) and after the edge.
  - SET=1, SETA=3 coincident with W0 to 3 -> busy[3] remains 1 after the edge.
- READ_REG=1: write 64'h42 to reg 9, SA=9 -> A=64'h42 one cycle later.
  - Assert reset mid-stream -> A=0 immediately, and reg 9 reads 0 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and depth helper for the 2-write/2-read register file.
package regfile_pkg;
    localparam int N_DEF        = 64;
    localparam int ADDR_W_DEF   = 5;
    localparam int ZERO_IDX_DEF = 31;

    function automatic int rf_depth(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: zero/bypass/priority value selection and busy masking for one read port.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_IDX = ZERO_IDX_DEF,
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0] sel,
    input  logic [N-1:0]      stored,
    input  logic              busy_bit,
    input  logic [N-1:0]      d0,
    input  logic [ADDR_W-1:0] da0,
    input  logic              w0,
    input  logic [N-1:0]      d1,
    input  logic [ADDR_W-1:0] da1,
    input  logic              w1,
    output logic [N-1:0]      val,
    output logic              busy
);
    logic is_zero, hit0, hit1;

    assign is_zero = (HAS_ZERO != 0) && (sel == ADDR_W'(ZERO_IDX));
    assign hit0    = (BYPASS != 0) && w0 && (da0 == sel);
    assign hit1    = (BYPASS != 0) && w1 && (da1 == sel);
    // Port 1 is checked first so it wins on a shared address.
    assign val     = is_zero ? '0 : hit1 ? d1 : hit0 ? d0 : stored;
    assign busy    = busy_bit & ~hit0 & ~hit1 & ~is_zero;
endmodule

// File: rtl/regfile_2w2r_sb.sv
// regfile_2w2r_sb: two-write/two-read register file with optional bypass,
// registered reads, hardwired zero and a per-register busy scoreboard.
module regfile_2w2r_sb
    import regfile_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_IDX = ZERO_IDX_DEF,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      D0,
    input  logic [ADDR_W-1:0] DA0,
    input  logic              W0,
    input  logic [N-1:0]      D1,
    input  logic [ADDR_W-1:0] DA1,
    input  logic              W1,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    input  logic              SET,
    input  logic [ADDR_W-1:0] SETA,
    output logic [N-1:0]      A,
    output logic [N-1:0]      B,
    output logic              A_busy,
    output logic              B_busy
);
    localparam int DEPTH = rf_depth(ADDR_W);

    logic [N-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] busy, busy_nxt;
    logic             zero0, zero1;
    logic [N-1:0]     va, vb;

    assign zero0 = (HAS_ZERO != 0) && (DA0 == ADDR_W'(ZERO_IDX));
    assign zero1 = (HAS_ZERO != 0) && (DA1 == ADDR_W'(ZERO_IDX));

    // Port 1 is assigned last so its write takes effect on a shared address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (W0 && !zero0) mem[DA0] <= D0;
            if (W1 && !zero1) mem[DA1] <= D1;
        end
    end

    // A new producer (SET) supersedes a completing write to the same register.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < DEPTH; i++)
            busy_nxt[i] = (busy[i] & ~(W0 && DA0 == ADDR_W'(i)) & ~(W1 && DA1 == ADDR_W'(i)))
                        | (SET && SETA == ADDR_W'(i));
        if (HAS_ZERO != 0) busy_nxt[ZERO_IDX] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= busy_nxt;
    end

    rf_read_port #(.N(N), .ADDR_W(ADDR_W), .HAS_ZERO(HAS_ZERO), .ZERO_IDX(ZERO_IDX), .BYPASS(BYPASS)) u_port_a (
        .sel(SA), .stored(mem[SA]), .busy_bit(busy[SA]),
        .d0(D0), .da0(DA0), .w0(W0), .d1(D1), .da1(DA1), .w1(W1),
        .val(va), .busy(A_busy)
    );

    rf_read_port #(.N(N), .ADDR_W(ADDR_W), .HAS_ZERO(HAS_ZERO), .ZERO_IDX(ZERO_IDX), .BYPASS(BYPASS)) u_port_b (
        .sel(SB), .stored(mem[SB]), .busy_bit(busy[SB]),
        .d0(D0), .da0(DA0), .w0(W0), .d1(D1), .da1(DA1), .w1(W1),
        .val(vb), .busy(B_busy)
    );

    generate
        if (READ_REG != 0) begin : g_reg
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    A <= '0;
                    B <= '0;
                end else begin
                    A <= va;
                    B <= vb;
                end
            end
        end else begin : g_comb
            assign A = va;
            assign B = vb;
        end
    endgenerate
endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// tb_regfile_2w2r_sb: scoreboard bench for combinational and registered-read variants.
module tb_regfile_2w2r_sb;
    localparam int N = 64, AW = 5, DEPTH = 32, ZI = 31;

    logic clock = 1'b0, reset = 1'b1;
    logic [N-1:0]  D0 = '0, D1 = '0;
    logic [AW-1:0] DA0 = '0, DA1 = '0, SA = '0, SB = '0, SETA = '0;
    logic          W0 = 1'b0, W1 = 1'b0, SET = 1'b0;
    logic [N-1:0]  A0, B0, A1, B1;
    logic          Ab0, Bb0, Ab1, Bb1;

    always #5 clock = ~clock;

    regfile_2w2r_sb #(.READ_REG(0)) dut (
        .clock(clock), .reset(reset), .D0(D0), .DA0(DA0), .W0(W0), .D1(D1), .DA1(DA1), .W1(W1),
        .SA(SA), .SB(SB), .SET(SET), .SETA(SETA), .A(A0), .B(B0), .A_busy(Ab0), .B_busy(Bb0)
    );

    regfile_2w2r_sb #(.READ_REG(1)) dut_r (
        .clock(clock), .reset(reset), .D0(D0), .DA0(DA0), .W0(W0), .D1(D1), .DA1(DA1), .W1(W1),
        .SA(SA), .SB(SB), .SET(SET), .SETA(SETA), .A(A1), .B(B1), .A_busy(Ab1), .B_busy(Bb1)
    );

    logic [N-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] bsy;
    logic [N-1:0]     qa[$], qb[$], qra[$], qrb[$];
    logic [N-1:0]     exp_v;
    logic             exp_b;
    int compared = 0, mismatched = 0;

    function automatic logic [N-1:0] vsel(input logic [AW-1:0] s);
        if (s == AW'(ZI)) return '0;
        if (W1 && DA1 == s) return D1;
        if (W0 && DA0 == s) return D0;
        return mem[s];
    endfunction

    function automatic logic bsel(input logic [AW-1:0] s);
        return bsy[s] && !(W0 && DA0 == s) && !(W1 && DA1 == s) && s != AW'(ZI);
    endfunction

    task automatic drive(input logic w0, input logic [AW-1:0] da0, input logic [N-1:0] d0,
                         input logic w1, input logic [AW-1:0] da1, input logic [N-1:0] d1,
                         input logic [AW-1:0] sa, input logic [AW-1:0] sb,
                         input logic set, input logic [AW-1:0] seta);
        W0 = w0; DA0 = da0; D0 = d0; W1 = w1; DA1 = da1; D1 = d1;
        SA = sa; SB = sb; SET = set; SETA = seta;
        qa.push_back(vsel(SA));
        qb.push_back(vsel(SB));
    endtask

    task automatic tick;
        logic [DEPTH-1:0] nb;
        qra.push_back(vsel(SA));
        qrb.push_back(vsel(SB));
        @(posedge clock);
        for (int i = 0; i < DEPTH; i++)
            nb[i] = (bsy[i] && !(W0 && DA0 == AW'(i)) && !(W1 && DA1 == AW'(i))) || (SET && SETA == AW'(i));
        nb[ZI] = 1'b0;
        bsy = nb;
        if (W0 && DA0 != AW'(ZI)) mem[DA0] = D0;
        if (W1 && DA1 != AW'(ZI)) mem[DA1] = D1;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bsy = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        compared++;
        if (A1 !== '0 || B1 !== '0) begin
            mismatched++;
            $display("FAIL reset_regout: A=%h B=%h want 0", A1, B1);
        end
        for (int s = 0; s < DEPTH; s++) begin
            drive(0, 0, 0, 0, 0, 0, AW'(s), AW'(DEPTH - 1 - s), 0, 0);
            #1;
            exp_v = qa.pop_front();
            compared++;
            if (A0 !== exp_v || Ab0 !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_read_a[%0d]: A=%h busy=%b want %h busy=0", s, A0, Ab0, exp_v);
            end
            exp_v = qb.pop_front();
            compared++;
            if (B0 !== exp_v || Bb0 !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_read_b[%0d]: B=%h busy=%b want %h busy=0", s, B0, Bb0, exp_v);
            end
        end
    endtask

    task automatic test_write_bypass;
        qra.delete(); qrb.delete();
        drive(1, 5, 64'h1234, 0, 0, 0, 5, 0, 0, 0);
        #1;
        exp_v = qa.pop_front(); void'(qb.pop_front());
        compared++;
        if (A0 !== exp_v) begin mismatched++; $display("FAIL bypass_same_cycle: A=%h want %h", A0, exp_v); end
        tick;
        exp_v = qra.pop_front(); void'(qrb.pop_front());
        compared++;
        if (A1 !== exp_v) begin mismatched++; $display("FAIL bypass_regread: A=%h want %h", A1, exp_v); end
        drive(0, 0, 0, 0, 0, 0, 5, 5, 0, 0);
        #1;
        exp_v = qa.pop_front();
        compared++;
        if (A0 !== exp_v) begin mismatched++; $display("FAIL write_stored_a: A=%h want %h", A0, exp_v); end
        exp_v = qb.pop_front();
        compared++;
        if (B0 !== exp_v) begin mismatched++; $display("FAIL write_stored_b: B=%h want %h", B0, exp_v); end
    endtask

    task automatic test_priority;
        qra.delete(); qrb.delete();
        drive(1, 7, 64'hAAAA, 1, 7, 64'h5555, 7, 7, 0, 0);
        #1;
        exp_v = qa.pop_front(); void'(qb.pop_front());
        compared++;
        if (A0 !== exp_v) begin mismatched++; $display("FAIL prio_bypass: A=%h want %h", A0, exp_v); end
        tick;
        exp_v = qra.pop_front(); void'(qrb.pop_front());
        compared++;
        if (A1 !== exp_v) begin mismatched++; $display("FAIL prio_regread: A=%h want %h", A1, exp_v); end
        drive(0, 0, 0, 0, 0, 0, 7, 7, 0, 0);
        #1;
        exp_v = qa.pop_front();
        compared++;
        if (A0 !== exp_v) begin mismatched++; $display("FAIL prio_stored_a: A=%h want %h", A0, exp_v); end
        exp_v = qb.pop_front();
        compared++;
        if (B0 !== exp_v) begin mismatched++; $display("FAIL prio_stored_b: B=%h want %h", B0, exp_v); end
        // Port 0 alone to a different register, port 1 elsewhere: both land.
        drive(1, 2, 64'hBEEF, 1, 4, 64'hCAFE, 2, 4, 0, 0);
        tick;
        void'(qa.pop_front()); void'(qb.pop_front());
        exp_v = qra.pop_front();
        compared++;
        if (A1 !== exp_v) begin mismatched++; $display("FAIL dual_write_a: A=%h want %h", A1, exp_v); end
        exp_v = qrb.pop_front();
        compared++;
        if (B1 !== exp_v) begin mismatched++; $display("FAIL dual_write_b: B=%h want %h", B1, exp_v); end
    endtask

    task automatic test_zero;
        qra.delete(); qrb.delete();
        drive(1, 31, 64'hFFFF, 1, 31, 64'hFFFF, 31, 31, 1, 31);
        #1;
        exp_v = qa.pop_front(); void'(qb.pop_front());
        compared++;
        if (A0 !== exp_v) begin mismatched++; $display("FAIL zero_bypass: A=%h want %h", A0, exp_v); end
        tick;
        exp_v = qra.pop_front(); void'(qrb.pop_front());
        compared++;
        if (A1 !== exp_v) begin mismatched++; $display("FAIL zero_regread: A=%h want %h", A1, exp_v); end
        drive(0, 0, 0, 0, 0, 0, 31, 31, 0, 0);
        #1;
        exp_v = qa.pop_front(); void'(qb.pop_front());
        exp_b = bsel(SA);
        compared++;
        if (A0 !== exp_v || Ab0 !== exp_b) begin
            mismatched++;
            $display("FAIL zero_stored: A=%h busy=%b want %h busy=%b", A0, Ab0, exp_v, exp_b);
        end
    endtask

    task automatic test_busy;
        qra.delete(); qrb.delete();
        drive(0, 0, 0, 0, 0, 0, 3, 3, 1, 3);
        tick;
        void'(qa.pop_front()); void'(qb.pop_front());
        drive(0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
        #1;
        void'(qa.pop_front()); void'(qb.pop_front());
        exp_b = bsel(3);
        compared++;
        if (Ab0 !== exp_b || Bb0 !== exp_b) begin
            mismatched++;
            $display("FAIL busy_set: A_busy=%b B_busy=%b want %b", Ab0, Bb0, exp_b);
        end
        compared++;
        if (Ab1 !== exp_b) begin mismatched++; $display("FAIL busy_set_regmode: A_busy=%b want %b", Ab1, exp_b); end
        drive(1, 3, 64'h77, 0, 0, 0, 3, 3, 0, 0);
        #1;
        void'(qa.pop_front()); void'(qb.pop_front());
        exp_b = bsel(3);
        compared++;
        if (Ab0 !== exp_b) begin mismatched++; $display("FAIL busy_clear_bypass: A_busy=%b want %b", Ab0, exp_b); end
        tick;
        drive(0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
        #1;
        void'(qa.pop_front()); void'(qb.pop_front());
        exp_b = bsel(3);
        compared++;
        if (Ab0 !== exp_b) begin mismatched++; $display("FAIL busy_cleared: A_busy=%b want %b", Ab0, exp_b); end
        drive(1, 3, 64'h88, 0, 0, 0, 3, 3, 1, 3);
        tick;
        void'(qa.pop_front()); void'(qb.pop_front());
        drive(0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
        #1;
        void'(qa.pop_front()); void'(qb.pop_front());
        exp_b = bsel(3);
        compared++;
        if (Ab0 !== exp_b || Bb0 !== exp_b) begin
            mismatched++;
            $display("FAIL busy_set_wins: A_busy=%b B_busy=%b want %b", Ab0, Bb0, exp_b);
        end
        // Port 1 write also clears the scoreboard bit.
        drive(0, 0, 0, 1, 3, 64'h99, 3, 3, 0, 0);
        tick;
        void'(qa.pop_front()); void'(qb.pop_front());
        drive(0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
        #1;
        void'(qa.pop_front()); void'(qb.pop_front());
        exp_b = bsel(3);
        compared++;
        if (Bb0 !== exp_b) begin mismatched++; $display("FAIL busy_clear_w1: B_busy=%b want %b", Bb0, exp_b); end
    endtask

    task automatic test_regread_reset;
        qra.delete(); qrb.delete();
        drive(1, 9, 64'h42, 0, 0, 0, 9, 9, 0, 0);
        tick;
        void'(qa.pop_front()); void'(qb.pop_front());
        exp_v = qra.pop_front(); void'(qrb.pop_front());
        compared++;
        if (A1 !== exp_v) begin mismatched++; $display("FAIL regread_latency: A=%h want %h", A1, exp_v); end
        drive(1, 9, 64'h99, 0, 0, 0, 9, 9, 1, 9);
        void'(qa.pop_front()); void'(qb.pop_front());
        #2 reset = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        bsy = '0;
        compared++;
        if (A1 !== '0 || B1 !== '0) begin
            mismatched++;
            $display("FAIL reset_async: A=%h B=%h want 0", A1, B1);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        qra.delete(); qrb.delete();
        drive(0, 0, 0, 0, 0, 0, 9, 9, 0, 0);
        #1;
        exp_v = qa.pop_front(); void'(qb.pop_front());
        exp_b = bsel(9);
        compared++;
        if (A0 !== exp_v || Ab0 !== exp_b) begin
            mismatched++;
            $display("FAIL reset_discard: A=%h busy=%b want %h busy=%b", A0, Ab0, exp_v, exp_b);
        end
        tick;
        exp_v = qra.pop_front(); void'(qrb.pop_front());
        compared++;
        if (A1 !== exp_v) begin mismatched++; $display("FAIL reset_regread: A=%h want %h", A1, exp_v); end
    endtask

    initial begin
        test_reset;
        test_write_bypass;
        test_priority;
        test_zero;
        test_busy;
        test_regread_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
